// File: rtl/tdc_coarse_counter.sv
// Coarse time-to-digital converter: counts clk periods between a rising
// edge on start and a rising edge on stop. The result saturates at MAX when
// no stop arrives, and it is held until the consumer accepts it (valid && rdy).
module tdc_coarse_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             stop,
    input  logic             rdy,
    output logic [WIDTH-1:0] tdc_out,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(32'd1);

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] tdc_r;
    logic             ovf_r;
    logic             valid_r;
    logic             busy_r;
    logic             start_prev_r;
    logic             stop_prev_r;
    logic             start_ev_s;
    logic             stop_ev_s;

    // Rising-edge detection of the start/stop levels against last cycle's sample
    always_comb begin
        start_ev_s = start & ~start_prev_r;
        stop_ev_s  = stop & ~stop_prev_r;
    end

    // Previous-sample registers; they keep updating in every state, so a level
    // held across HOLD->IDLE never looks like a new edge
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            start_prev_r <= 1'b0;
            stop_prev_r  <= 1'b0;
        end else begin
            start_prev_r <= start;
            stop_prev_r  <= stop;
        end
    end

    // Measurement FSM with registered result, status and handshake outputs
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= IDLE;
            cnt_r   <= ZERO;
            tdc_r   <= ZERO;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_ev_s && stop_ev_s) begin
                        // Zero-length interval: report it without counting
                        state_r <= HOLD;
                        cnt_r   <= ZERO;
                        tdc_r   <= ZERO;
                        ovf_r   <= 1'b0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (start_ev_s) begin
                        state_r <= COUNT;
                        cnt_r   <= ZERO;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                COUNT: begin
                    if (cnt_r == MAX) begin
                        // Counter is saturated; the interval cannot be represented
                        state_r <= HOLD;
                        cnt_r   <= ZERO;
                        tdc_r   <= MAX;
                        ovf_r   <= 1'b1;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (stop_ev_s) begin
                        // cnt holds k-1 on the edge before the stop edge n+k
                        state_r <= HOLD;
                        cnt_r   <= ZERO;
                        tdc_r   <= cnt_r + ONE;
                        ovf_r   <= 1'b0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= COUNT;
                        cnt_r   <= cnt_r + ONE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (rdy) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= HOLD;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= ZERO;
                    tdc_r   <= ZERO;
                    ovf_r   <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tdc_out = tdc_r;
    assign ovf     = ovf_r;
    assign valid   = valid_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_tdc_coarse_counter.sv
// Self-checking bench for tdc_coarse_counter (WIDTH=4): a constant vector
// table followed by hand-written multi-cycle sequences, all through a
// scoreboard queue of expected output records.
module tb_tdc_coarse_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rstb;
    logic         start;
    logic         stop;
    logic         rdy;
    logic [W-1:0] tdc_out;
    logic         valid;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         busy;
        logic         valid;
        logic         ovf;
        logic [W-1:0] tdc;
    } exp_t;

    typedef struct packed {
        logic s;
        logic p;
        logic r;
        exp_t e;
    } vec_t;

    exp_t         sb_q[$];
    vec_t         vecs[16];
    logic [W-1:0] last_tdc;
    logic         last_ovf;

    tdc_coarse_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .start   (start),
        .stop    (stop),
        .rdy     (rdy),
        .tdc_out (tdc_out),
        .valid   (valid),
        .ovf     (ovf),
        .busy    (busy)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic s, input logic p, input logic r,
                                 input logic b, input logic v, input logic o,
                                 input logic [W-1:0] t);
        vec_t x;
        x.s = s; x.p = p; x.r = r;
        x.e.busy = b; x.e.valid = v; x.e.ovf = o; x.e.tdc = t;
        return x;
    endfunction

    function automatic exp_t idle_e();
        exp_t x;
        x.busy = 1'b0; x.valid = 1'b0; x.ovf = last_ovf; x.tdc = last_tdc;
        return x;
    endfunction

    function automatic exp_t count_e();
        exp_t x;
        x.busy = 1'b1; x.valid = 1'b0; x.ovf = last_ovf; x.tdc = last_tdc;
        return x;
    endfunction

    function automatic exp_t hold_e(input logic [W-1:0] t, input logic o);
        exp_t x;
        x.busy = 1'b0; x.valid = 1'b1; x.ovf = o; x.tdc = t;
        return x;
    endfunction

    task automatic check_now(input string nm, input exp_t e);
        checks++;
        if ({busy, valid, ovf, tdc_out} !== e) begin
            errors++;
            $display("FAIL %s: got busy=%0b valid=%0b ovf=%0b tdc=%0d, expected busy=%0b valid=%0b ovf=%0b tdc=%0d",
                     nm, busy, valid, ovf, tdc_out, e.busy, e.valid, e.ovf, e.tdc);
        end
    endtask

    // One clock: drive at negedge, queue the expectation, compare after posedge
    task automatic step(input logic s, input logic p, input logic r,
                        input exp_t e, input string nm);
        @(negedge clk);
        start = s; stop = p; rdy = r;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_now(nm, sb_q.pop_front());
    endtask

    task automatic do_reset(input logic start_lvl);
        @(negedge clk);
        rstb = 1'b0; start = start_lvl; stop = 1'b0; rdy = 1'b1;
        #1;
        last_tdc = '0; last_ovf = 1'b0;
        check_now("reset_async", idle_e());
        @(negedge clk);
        rstb = 1'b1;
    endtask

    initial begin
        rstb = 1'b0; start = 1'b0; stop = 1'b0; rdy = 1'b1;
        last_tdc = '0; last_ovf = 1'b0;
        #12;
        check_now("reset_state", idle_e());
        @(negedge clk);
        rstb = 1'b1;

        //            s     p     r     busy  valid ovf   tdc
        vecs[0]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        vecs[1]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0); // stop in IDLE ignored
        vecs[2]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        vecs[3]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0); // start+stop together
        vecs[4]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        vecs[5]  = mkv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0); // start, cnt=0
        vecs[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        vecs[7]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        vecs[8]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3); // stop at k=3
        vecs[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3); // rdy low: held
        vecs[10] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3); // accepted, tdc retained
        vecs[11] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3); // stop rises in IDLE
        vecs[12] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3); // stop held: no stop event
        vecs[13] = mkv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        vecs[14] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2); // stop at k=2
        vecs[15] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].s, vecs[i].p, vecs[i].r, vecs[i].e, $sformatf("vec%0d", i));
        end
        last_tdc = 4'd2; last_ovf = 1'b0;

        // Basic interval of 5 periods from a fresh reset
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, idle_e(), "k5_idle");
        step(1'b1, 1'b0, 1'b1, count_e(), "k5_start");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, count_e(), "k5_busy");
        step(1'b0, 1'b1, 1'b1, hold_e(4'd5, 1'b0), "k5_result");
        last_tdc = 4'd5; last_ovf = 1'b0;
        step(1'b0, 1'b0, 1'b1, idle_e(), "k5_idle_after");

        // Overflow with start held high through measurement and handshake
        step(1'b1, 1'b0, 1'b1, count_e(), "ovf_start");
        for (int j = 1; j <= 15; j++) step(1'b1, 1'b0, 1'b1, count_e(), "ovf_busy");
        step(1'b1, 1'b0, 1'b1, hold_e(4'd15, 1'b1), "ovf_result");
        last_tdc = 4'd15; last_ovf = 1'b1;
        step(1'b1, 1'b0, 1'b1, idle_e(), "ovf_accept");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, idle_e(), "start_held_no_restart");
        step(1'b0, 1'b0, 1'b1, idle_e(), "start_low");

        // Stop exactly at n+MAX: full-scale result without overflow
        step(1'b1, 1'b0, 1'b1, count_e(), "max_start");
        for (int j = 1; j <= 14; j++) step(1'b0, 1'b0, 1'b1, count_e(), "max_busy");
        step(1'b0, 1'b1, 1'b1, hold_e(4'd15, 1'b0), "max_result");
        last_tdc = 4'd15; last_ovf = 1'b0;
        step(1'b0, 1'b0, 1'b1, idle_e(), "max_idle");

        // Result 7 held through 8 cycles of rdy=0 with stray start/stop pulses
        step(1'b1, 1'b0, 1'b1, count_e(), "k7_start");
        for (int j = 1; j <= 6; j++) step(1'b0, 1'b0, 1'b1, count_e(), "k7_busy");
        step(1'b0, 1'b1, 1'b1, hold_e(4'd7, 1'b0), "k7_result");
        for (int i = 0; i < 8; i++) begin
            step(i[0], i[1], 1'b0, hold_e(4'd7, 1'b0), "k7_hold");
        end
        last_tdc = 4'd7; last_ovf = 1'b0;
        step(1'b0, 1'b0, 1'b1, idle_e(), "k7_accept");
        step(1'b0, 1'b0, 1'b1, idle_e(), "k7_no_queued");

        // Asynchronous reset in the middle of COUNT at cnt=6
        step(1'b1, 1'b0, 1'b1, count_e(), "rst_mid_start");
        for (int j = 1; j <= 6; j++) step(1'b0, 1'b0, 1'b1, count_e(), "rst_mid_busy");
        @(negedge clk);
        #2;
        rstb = 1'b0;
        #1;
        last_tdc = '0; last_ovf = 1'b0;
        check_now("rst_mid_async", idle_e());
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, idle_e(), "rst_mid_no_valid");

        // First edge after reset release detects a start already high
        do_reset(1'b1);
        @(posedge clk);
        #1;
        check_now("rst_release_start", count_e());
        step(1'b1, 1'b1, 1'b1, hold_e(4'd1, 1'b0), "rst_release_k1");
        last_tdc = 4'd1; last_ovf = 1'b0;
        step(1'b1, 1'b0, 1'b1, idle_e(), "rst_release_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
